// File: rtl/instruction_load_arbiter.sv
// Round-robin front end that turns per-channel load toggles into AXI reads
// and unpacks each returned beat into instruction-memory words.
module instruction_load_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int AXI_ADDR_WIDTH  = 42,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int INST_DATA_WIDTH = 32,
    parameter int NUM_INST_IN     = AXI_DATA_WIDTH / INST_DATA_WIDTH,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int MEM_REQ_W       = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  ld_req_tgl,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   ld_addr,
    input  logic [NUM_REQ*MEM_REQ_W-1:0]        ld_size,
    output logic [NUM_REQ-1:0]                  ld_done_tgl,
    output logic [NUM_REQ-1:0]                  ld_overflow,
    output logic                                rd_req,
    input  logic                                rd_ready,
    output logic [AXI_ADDR_WIDTH-1:0]           rd_addr,
    output logic [MEM_REQ_W-1:0]                rd_req_size,
    input  logic                                rd_done,
    input  logic                                mem_write_req,
    input  logic [AXI_DATA_WIDTH-1:0]           mem_write_data,
    output logic                                mem_write_ready,
    output logic                                imem_wr_en,
    output logic [INST_ADDR_WIDTH-1:0]          imem_wr_addr,
    output logic [INST_DATA_WIDTH-1:0]          imem_wr_data,
    output logic                                busy,
    output logic [$clog2(NUM_REQ)-1:0]          active_ch
);

    localparam int CH_W   = $clog2(NUM_REQ);
    localparam int WIDX_W = (NUM_INST_IN > 1) ? $clog2(NUM_INST_IN) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, DRAIN, DONE} state_t;

    state_t                    state, state_n;
    logic [NUM_REQ-1:0]        tgl_d;
    logic [NUM_REQ-1:0]        pending;
    logic [NUM_REQ-1:0]        edge_det;
    logic [NUM_REQ-1:0]        gnt_mask;
    logic                      gnt_vld;
    logic                      grant;
    logic [CH_W-1:0]           gnt_idx;
    logic [CH_W-1:0]           rr_ptr;
    logic [MEM_REQ_W-1:0]      sel_size;
    logic [AXI_DATA_WIDTH-1:0] beat_buf;
    logic                      buf_vld;
    logic [WIDX_W-1:0]         widx;
    logic                      last_word;
    logic                      beat_acc;

    assign edge_det = ld_req_tgl ^ tgl_d;

    // First pending channel at or after rr_ptr, wrapping.
    always_comb begin : arb
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_vld && pending[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
    end

    assign grant     = (state == IDLE) && gnt_vld;
    assign gnt_mask  = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign sel_size  = ld_size[gnt_idx*MEM_REQ_W +: MEM_REQ_W];

    assign last_word    = buf_vld && (widx == WIDX_W'(NUM_INST_IN - 1));
    assign beat_acc     = mem_write_req && mem_write_ready;
    assign imem_wr_en   = buf_vld;
    assign imem_wr_data = beat_buf[widx*INST_DATA_WIDTH +: INST_DATA_WIDTH];
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n         = state;
        rd_req          = 1'b0;
        mem_write_ready = 1'b0;
        case (state)
            IDLE:   if (gnt_vld) state_n = (sel_size == '0) ? DONE : ISSUE;
            ISSUE: begin
                rd_req = 1'b1;
                if (rd_ready) state_n = STREAM;
            end
            STREAM: begin
                // Refill as the last word of the held beat goes out, so beats stream at one per NUM_INST_IN cycles.
                mem_write_ready = !buf_vld || last_word;
                if (rd_done) state_n = DRAIN;
            end
            DRAIN:  if (!buf_vld) state_n = DONE;
            DONE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgl_d        <= '0;
            pending      <= '0;
            ld_overflow  <= '0;
            ld_done_tgl  <= '0;
            rr_ptr       <= '0;
            rd_addr      <= '0;
            rd_req_size  <= '0;
            active_ch    <= '0;
            imem_wr_addr <= '0;
            beat_buf     <= '0;
            buf_vld      <= 1'b0;
            widx         <= '0;
        end else begin
            tgl_d <= ld_req_tgl;
            // A toggle landing on the grant cycle re-arms the channel instead of merging.
            pending     <= (pending & ~gnt_mask) | edge_det;
            ld_overflow <= ld_overflow | (edge_det & pending & ~gnt_mask);

            if (grant) begin
                rr_ptr       <= (gnt_idx == CH_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                rd_addr      <= ld_addr[gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                rd_req_size  <= sel_size;
                active_ch    <= gnt_idx;
                imem_wr_addr <= '0;
            end else if (buf_vld) begin
                imem_wr_addr <= imem_wr_addr + 1'b1;
            end

            if (buf_vld && !last_word) begin
                widx <= widx + 1'b1;
            end else if (beat_acc) begin
                beat_buf <= mem_write_data;
                buf_vld  <= 1'b1;
                widx     <= '0;
            end else begin
                buf_vld <= 1'b0;
                widx    <= '0;
            end

            if (state == DONE) ld_done_tgl[active_ch] <= ~ld_done_tgl[active_ch];
        end
    end

endmodule

// File: tb/tb_instruction_load_arbiter.sv
// Directed bench for instruction_load_arbiter: 4 channels, 2 words per beat,
// 3-bit instruction address so address wrap is reachable.
module tb_instruction_load_arbiter;

    localparam int NR  = 4;
    localparam int AW  = 42;
    localparam int DW  = 64;
    localparam int IW  = 32;
    localparam int IAW = 3;
    localparam int SW  = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   ld_req_tgl;
    logic [NR*AW-1:0] ld_addr;
    logic [NR*SW-1:0] ld_size;
    logic [NR-1:0]   ld_done_tgl;
    logic [NR-1:0]   ld_overflow;
    logic            rd_req;
    logic            rd_ready;
    logic [AW-1:0]   rd_addr;
    logic [SW-1:0]   rd_req_size;
    logic            rd_done;
    logic            mem_write_req;
    logic [DW-1:0]   mem_write_data;
    logic            mem_write_ready;
    logic            imem_wr_en;
    logic [IAW-1:0]  imem_wr_addr;
    logic [IW-1:0]   imem_wr_data;
    logic            busy;
    logic [1:0]      active_ch;

    instruction_load_arbiter #(
        .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .INST_DATA_WIDTH(IW), .INST_ADDR_WIDTH(IAW), .MEM_REQ_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .ld_req_tgl(ld_req_tgl), .ld_addr(ld_addr),
        .ld_size(ld_size), .ld_done_tgl(ld_done_tgl), .ld_overflow(ld_overflow),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_req_size(rd_req_size), .rd_done(rd_done), .mem_write_req(mem_write_req),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data), .busy(busy), .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int flips  = 0;
    logic [NR-1:0]      done_prev = '0;
    logic [NR-1:0]      exp_done  = '0;
    logic [DW-1:0]      bq[$];
    logic [IAW+IW-1:0]  wq[$];

    // Word and done-toggle monitor.
    always @(negedge clk) begin
        if (imem_wr_en && !reset) wq.push_back({imem_wr_addr, imem_wr_data});
        if (reset) begin
            done_prev <= '0;
        end else begin
            flips     <= flips + $countones(ld_done_tgl ^ done_prev);
            done_prev <= ld_done_tgl;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [SW-1:0] s);
        ld_addr[ch*AW +: AW] = a;
        ld_size[ch*SW +: SW] = s;
    endtask

    task automatic toggle(input int ch);
        ld_req_tgl[ch] = ~ld_req_tgl[ch];
    endtask

    task automatic load_beats(input int n, input logic [31:0] base);
        bq.delete();
        for (int k = 0; k < n; k++) bq.push_back({base + 32'(2*k + 1), base + 32'(2*k)});
    endtask

    task automatic wait_issue(input int ch, input logic [AW-1:0] a, input logic [SW-1:0] s);
        int n = 0;
        while (!rd_req && n < 50) begin @(negedge clk); n++; end
        chk("rd_req_seen", 64'(rd_req), 64'd1);
        chk("rd_addr", 64'(rd_addr), 64'(a));
        chk("rd_req_size", 64'(rd_req_size), 64'(s));
        chk("active_ch", 64'(active_ch), 64'(ch));
        wq.delete();
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("rd_req_drop", 64'(rd_req), 64'd0);
    endtask

    task automatic send_beats(output int stalls);
        int b = 0;
        int n = 0;
        stalls = 0;
        while (b < bq.size() && n < 200) begin
            mem_write_req  = 1'b1;
            mem_write_data = bq[b];
            if (mem_write_ready) b++;
            else stalls++;
            @(negedge clk);
            n++;
        end
        mem_write_req = 1'b0;
        chk("beats_sent", 64'(b), 64'(bq.size()));
    endtask

    task automatic finish_load(input int ch, output logic drained);
        int n  = 0;
        int f0 = flips;
        logic [DW-1:0] bt;
        logic [IW-1:0] w;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        drained = imem_wr_en && !mem_write_ready;
        while (busy && n < 100) begin @(negedge clk); n++; end
        chk("load_idle", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("word_count", 64'(wq.size()), 64'(2 * bq.size()));
        for (int i = 0; i < wq.size() && i < 2 * bq.size(); i++) begin
            bt = bq[i/2];
            w  = (i % 2 == 1) ? bt[63:32] : bt[31:0];
            chk("word", 64'(wq[i]), 64'({IAW'(i), w}));
        end
        exp_done[ch] = ~exp_done[ch];
        chk("done_tgl", 64'(ld_done_tgl), 64'(exp_done));
        chk("done_flips", 64'(flips - f0), 64'd1);
    endtask

    initial begin
        int   st;
        logic dr;
        int   f0;
        reset = 1'b1; ld_req_tgl = '0; ld_addr = '0; ld_size = '0;
        rd_ready = 1'b0; rd_done = 1'b0; mem_write_req = 1'b0; mem_write_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(imem_wr_en), 64'd0);
        chk("rst_ready", 64'(mem_write_ready), 64'd0);
        chk("rst_done", 64'(ld_done_tgl), 64'd0);
        chk("rst_ovf", 64'(ld_overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single load on ch0, rd_req two cycles after the toggle.
        set_ch(0, 42'h1000, 16'd2);
        bq.delete();
        bq.push_back(64'h0000000B_0000000A);
        bq.push_back(64'h0000000D_0000000C);
        toggle(0);
        @(negedge clk);
        chk("lat_t1", 64'(rd_req), 64'd0);
        @(negedge clk);
        chk("lat_t2", 64'(rd_req), 64'd1);
        wait_issue(0, 42'h1000, 16'd2);
        send_beats(st);
        finish_load(0, dr);

        // Zero-size load on ch1: no read, done two cycles after grant.
        set_ch(1, 42'h2000, 16'd0);
        toggle(1);
        @(negedge clk);
        chk("z_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        chk("z_busy1", 64'(busy), 64'd1);
        chk("z_no_rd", 64'(rd_req), 64'd0);
        chk("z_ch", 64'(active_ch), 64'd1);
        @(negedge clk);
        exp_done[1] = ~exp_done[1];
        chk("z_done", 64'(ld_done_tgl), 64'(exp_done));
        chk("z_idle", 64'(busy), 64'd0);

        // Round robin from rr_ptr=2: ch3 before ch1.
        set_ch(1, 42'h3000, 16'd1);
        set_ch(3, 42'h4000, 16'd1);
        toggle(1); toggle(3);
        load_beats(1, 32'h100);
        wait_issue(3, 42'h4000, 16'd1);
        send_beats(st);
        finish_load(3, dr);
        load_beats(1, 32'h200);
        wait_issue(1, 42'h3000, 16'd1);
        send_beats(st);
        finish_load(1, dr);

        // ch2 toggles during ch0 stream; second toggle overflows and merges.
        set_ch(0, 42'h5000, 16'd2);
        toggle(0);
        load_beats(2, 32'h300);
        wait_issue(0, 42'h5000, 16'd2);
        toggle(2);
        repeat (2) @(negedge clk);
        chk("ovf_first", 64'(ld_overflow), 64'd0);
        toggle(2);
        repeat (2) @(negedge clk);
        chk("ovf_second", 64'(ld_overflow), 64'b0100);
        set_ch(2, 42'h6000, 16'd1);
        send_beats(st);
        finish_load(0, dr);
        load_beats(1, 32'h400);
        wait_issue(2, 42'h6000, 16'd1);
        send_beats(st);
        finish_load(2, dr);
        repeat (10) @(negedge clk);
        chk("once_busy", 64'(busy), 64'd0);
        chk("once_rd", 64'(rd_req), 64'd0);

        // Back-to-back beats: ready every other cycle, rd_done lands before the last word.
        set_ch(3, 42'h7000, 16'd4);
        toggle(3);
        load_beats(4, 32'h500);
        wait_issue(3, 42'h7000, 16'd4);
        send_beats(st);
        chk("stalls", 64'(st), 64'd3);
        finish_load(3, dr);
        chk("drain", 64'(dr), 64'd1);

        // Five beats into a 3-bit address space: wraps 7 -> 0.
        set_ch(0, 42'h9000, 16'd5);
        toggle(0);
        load_beats(5, 32'h600);
        wait_issue(0, 42'h9000, 16'd5);
        send_beats(st);
        finish_load(0, dr);

        // Reset mid-stream, then a fresh load.
        set_ch(3, 42'h8000, 16'd2);
        toggle(3);
        wait_issue(3, 42'h8000, 16'd2);
        mem_write_req = 1'b1; mem_write_data = 64'h0000_0777_0000_0666;
        @(negedge clk);
        mem_write_req = 1'b0;
        @(negedge clk);
        chk("mid_stream_wr", 64'(imem_wr_en), 64'd1);
        f0 = flips;
        reset = 1'b1; ld_req_tgl = '0;
        @(negedge clk);
        exp_done = '0;
        chk("mr_rd_req", 64'(rd_req), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_wr_en", 64'(imem_wr_en), 64'd0);
        chk("mr_ready", 64'(mem_write_ready), 64'd0);
        chk("mr_done", 64'(ld_done_tgl), 64'd0);
        chk("mr_ovf", 64'(ld_overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_no_flip", 64'(flips - f0), 64'd0);
        set_ch(1, 42'hA000, 16'd1);
        toggle(1);
        load_beats(1, 32'h700);
        wait_issue(1, 42'hA000, 16'd1);
        send_beats(st);
        finish_load(1, dr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
